// File: rtl/rand_req_responder_pkg.sv
// Shared types and constants for the random-access port responder.
package rand_req_responder_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    REFRESH = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/rand_req_ram.sv
// Single-port byte-enabled RAM, one storage array per byte lane, registered read.
module rand_req_ram
  import rand_req_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] q;

    // Writes are gated by reset so an access cut short by reset never lands.
    always_ff @(posedge clk)
      if (rst_n && en && we && be[i]) mem[addr] <= wdata[BYTE_W*i +: BYTE_W];

    // Read register only moves on reads, so it doubles as the held read data.
    always_ff @(posedge clk)
      if (!rst_n)         q <= '0;
      else if (en && !we) q <= mem[addr];

    assign rdata[BYTE_W*i +: BYTE_W] = q;
  end
endmodule

// File: rtl/rand_req_responder.sv
// Controller-like responder for the random-access port, backed by on-chip RAM.
// Optional counters: define RAND_REQ_RESPONDER_STATS_EN.
module rand_req_responder
  import rand_req_responder_pkg::*;
#(
  parameter int ADDR_W         = 26,
  parameter int DEPTH_LOG2     = 10,
  parameter int LATENCY        = 4,
  parameter int REFRESH_CYCLES = 16
) (
  input  logic              CLK_n,
  input  logic              RST,
  input  logic              refresh_strobe,
  input  logic              rand_req,
  input  logic              rand_req_we,
  input  logic [BE_W-1:0]   rand_req_we_array,
  input  logic [ADDR_W-1:0] rand_req_address,
  input  logic [DATA_W-1:0] rand_req_datain,
  output logic              rand_req_ack,
  output logic [DATA_W-1:0] user_req_dataout,
`ifdef RAND_REQ_RESPONDER_STATS_EN
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [15:0]       stat_refreshes,
`endif
  output logic              busy
);
  state_t                state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic                  refresh_q, pending, ref_edge, pend_eff;
  logic                  take_ref, take_req, fire;
  req_t                  cap;
  logic [DEPTH_LOG2-1:0] cap_addr;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^rand_req_address[ADDR_W-1:DEPTH_LOG2];
  assign ref_edge       = refresh_strobe ^ refresh_q;
  // An edge seen this very cycle already counts, so IDLE can service it at once.
  assign pend_eff       = pending | ref_edge;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    take_ref = 1'b0;
    take_req = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE:
        if (pend_eff) begin
          state_n  = REFRESH;
          cnt_n    = 8'(REFRESH_CYCLES - 1);
          take_ref = 1'b1;
        end else if (rand_req) begin
          state_n  = ACCESS;
          cnt_n    = 8'(LATENCY - 1);
          take_req = 1'b1;
        end
      ACCESS:
        if (cnt == 8'd0) begin
          state_n = ACK;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      ACK:     state_n = IDLE;
      REFRESH:
        if (cnt == 8'd0) state_n = IDLE;
        else             cnt_n   = cnt - 8'd1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_n) begin
    refresh_q <= refresh_strobe;
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= take_ref ? 1'b0 : pend_eff;
    end
  end

  always_ff @(posedge CLK_n)
    if (take_req) begin
      cap      <= '{we: rand_req_we, be: rand_req_we_array, data: rand_req_datain};
      cap_addr <= rand_req_address[DEPTH_LOG2-1:0];
    end

  // RAM is driven in the last ACCESS cycle so its registered read lands in ACK.
  rand_req_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (CLK_n),
    .rst_n (RST),
    .en    (fire),
    .we    (cap.we),
    .be    (cap.be),
    .addr  (cap_addr),
    .wdata (cap.data),
    .rdata (user_req_dataout)
  );

  assign rand_req_ack = (state == ACK);
  assign busy         = (state != IDLE);

`ifdef RAND_REQ_RESPONDER_STATS_EN
  always_ff @(posedge CLK_n)
    if (!RST) begin
      stat_reads     <= '0;
      stat_writes    <= '0;
      stat_refreshes <= '0;
    end else begin
      if (fire && cap.we)  stat_writes    <= stat_writes + 32'd1;
      if (fire && !cap.we) stat_reads     <= stat_reads + 32'd1;
      if (take_ref)        stat_refreshes <= stat_refreshes + 16'd1;
    end
`endif
endmodule
